// File: rtl/pwm_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_frame_ctrl_if
// Function : Byte-stream link between the UART receiver/transmitter and the
//            PWM frame controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // master: UART side; slave: frame controller
  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/pwm_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_frame_ctrl
// Function : Parses checksummed UART frames and commits period/high-time
//            settings to the PWM channels, answering each frame with ACK/NAK.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_frame_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 24,
  parameter int TIMEOUT    = 500000,
  parameter int DEF_PERIOD = 50000,
  parameter int DEF_HIGH   = 1000
) (
  input  wire                     SCLOCK,
  input  wire                     RESET,
  pwm_frame_ctrl_if.slave         uart,
  output wire [NUM_CH*CNT_W-1:0]  period_o,
  output wire [NUM_CH*CNT_W-1:0]  high_o,
  output wire [NUM_CH-1:0]        ch_update,
  output wire [7:0]               err_cnt,
  output wire                     busy
);

  localparam logic [7:0]       c_HDR      = 8'hA5;
  localparam logic [7:0]       c_ACK      = 8'h06;
  localparam logic [7:0]       c_NAK      = 8'h15;
  localparam logic [3:0]       c_BCAST    = 4'hF;
  localparam int               c_IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_DEF_PER  = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] c_DEF_HIGH = CNT_W'(DEF_HIGH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_APPLY = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [7:0]            r_addr;
  logic [7:0]            r_xor;
  logic [2:0]            r_idx;
  logic [CNT_W-1:0]      r_per_sh;
  logic [CNT_W-1:0]      r_high_sh;
  logic                  r_chk_ok;
  logic [c_IDLE_W-1:0]   r_idle_cnt;

  logic [CNT_W-1:0]      r_period [NUM_CH];
  logic [CNT_W-1:0]      r_high   [NUM_CH];
  logic [NUM_CH-1:0]     r_upd;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic [7:0]            r_err_cnt;
  logic                  r_busy;

  logic                  w_in_frame;
  logic                  w_idle_exp;
  logic [3:0]            w_ch;
  logic                  w_bcast;
  logic                  w_ch_ok;
  logic                  w_valid;
  logic [NUM_CH-1:0]     w_sel;
  logic                  w_commit;
  logic                  w_reject;
  logic                  w_timeout;
  logic                  w_tx_done;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_idle_exp = !uart.rx_valid && (r_idle_cnt == c_IDLE_LAST);

  // Frame validation, evaluated while the FSM sits in APPLY
  assign w_ch    = r_addr[3:0];
  assign w_bcast = (w_ch == c_BCAST);
  assign w_ch_ok = w_bcast || ({28'd0, w_ch} < 32'(NUM_CH));
  assign w_valid = r_chk_ok
                && (r_addr[7:4] == 4'd0)
                && w_ch_ok
                && (r_per_sh >= CNT_W'(2))
                && (r_high_sh != '0)
                && (r_high_sh < r_per_sh);

  always_comb begin
    w_sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_sel[n] = w_bcast || (w_ch == 4'(n));
    end
  end

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    w_timeout   = 1'b0;
    w_tx_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (uart.rx_valid && (uart.rx_data == c_HDR)) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (uart.rx_valid) begin
          w_state_nxt = S_DATA;
        end else if (w_idle_exp) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_DATA: begin
        if (uart.rx_valid) begin
          if (r_idx == 3'd5) begin
            w_state_nxt = S_CHK;
          end
        end else if (w_idle_exp) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_CHK: begin
        if (uart.rx_valid) begin
          w_state_nxt = S_APPLY;
        end else if (w_idle_exp) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_APPLY: begin
        w_state_nxt = S_RESP;
        w_commit    = w_valid;
        w_reject    = !w_valid;
      end
      S_RESP: begin
        if (uart.tx_ready) begin
          w_state_nxt = S_IDLE;
          w_tx_done   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Byte capture into the shadow registers and running checksum
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      r_addr     <= '0;
      r_xor      <= '0;
      r_idx      <= '0;
      r_per_sh   <= '0;
      r_high_sh  <= '0;
      r_chk_ok   <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (w_in_frame && !uart.rx_valid && !w_idle_exp) begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
      end else begin
        r_idle_cnt <= '0;
      end

      if (uart.rx_valid) begin
        case (r_state)
          S_ADDR: begin
            r_addr    <= uart.rx_data;
            r_xor     <= uart.rx_data;
            r_idx     <= 3'd0;
            r_per_sh  <= '0;
            r_high_sh <= '0;
          end
          S_DATA: begin
            r_xor <= r_xor ^ uart.rx_data;
            r_idx <= r_idx + 3'd1;
            if (r_idx < 3'd3) begin
              r_per_sh  <= CNT_W'({r_per_sh, uart.rx_data});
            end else begin
              r_high_sh <= CNT_W'({r_high_sh, uart.rx_data});
            end
          end
          S_CHK: begin
            r_chk_ok <= (uart.rx_data == r_xor);
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Channel registers: all selected channels load in the same edge
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_period[n] <= c_DEF_PER;
        r_high[n]   <= c_DEF_HIGH;
      end
      r_upd <= '0;
    end else begin
      r_upd <= w_commit ? w_sel : '0;
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_commit && w_sel[n]) begin
          r_period[n] <= r_per_sh;
          r_high[n]   <= r_high_sh;
        end
      end
    end
  end

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_commit) begin
        r_tx_data  <= c_ACK;
        r_tx_valid <= 1'b1;
      end else if (w_reject) begin
        r_tx_data  <= c_NAK;
        r_tx_valid <= 1'b1;
      end else if (w_tx_done) begin
        r_tx_valid <= 1'b0;
      end
      if ((w_reject || w_timeout) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_pack
      assign period_o[n*CNT_W +: CNT_W] = r_period[n];
      assign high_o[n*CNT_W +: CNT_W]   = r_high[n];
    end
  endgenerate

  assign ch_update     = r_upd;
  assign err_cnt       = r_err_cnt;
  assign busy          = r_busy;
  assign uart.tx_data  = r_tx_data;
  assign uart.tx_valid = r_tx_valid;

endmodule
`default_nettype wire
